// File: rtl/keypad_scan_fifo_if.sv
// Event stream handshake between the keypad scanner and its consumer.
interface keypad_scan_fifo_if #(
  parameter int unsigned DATA_W = 5
) ();
  logic              evt_valid;
  logic              evt_ready;
  logic [DATA_W-1:0] evt_data;

  modport master (output evt_valid, output evt_data, input evt_ready);
  modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner with per-key debounce and a press/release event FIFO.
module keypad_scan_fifo #(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned DEBOUNCE   = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ROWS-1:0]         row,
  output logic [COLS-1:0]         col,
  keypad_scan_fifo_if.master      evt,
  output logic [ROWS*COLS-1:0]    key_state,
  output logic                    overflow,
  input  logic                    ovf_clr
);

  localparam int unsigned N      = ROWS * COLS;
  localparam int unsigned CODE_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned TW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW     = $clog2(DEBOUNCE + 1);
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned FW     = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WAIT, EVAL} state_t;

  logic [ROWS-1:0]   row_meta, row_sync;
  logic [TW-1:0]     tmr_q;
  logic              tick_c;

  state_t            state_q, state_d;
  logic [CW-1:0]     cur_col_q, cur_col_d, nxt_col_c;
  logic [RW-1:0]     r_q, r_d;
  logic [ROWS-1:0]   row_lat_q, row_lat_d;
  logic [COLS-1:0]   col_d;
  logic [N-1:0]      key_state_d;
  logic [DW-1:0]     cnt_q [N];
  logic [DW-1:0]     cnt_d [N];
  logic [CODE_W-1:0] k_c;
  logic              push_c;
  logic [CODE_W:0]   push_data_c;

  logic [CODE_W:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [FW-1:0]     fill_q, fill_d;
  logic              valid_q;
  logic              pop_c, full_c, wr_en_c, drop_c;

  // Two-flop synchroniser; rows idle high (no key pressed).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // Free-running column slot timer.
  assign tick_c = (tmr_q == TW'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmr_q <= '0;
    else        tmr_q <= tick_c ? '0 : tmr_q + TW'(1);
  end

  // Scan sequencing and serial per-key debounce of the latched column.
  always_comb begin
    state_d     = state_q;
    cur_col_d   = cur_col_q;
    r_d         = r_q;
    row_lat_d   = row_lat_q;
    col_d       = col;
    key_state_d = key_state;
    cnt_d       = cnt_q;
    push_c      = 1'b0;
    push_data_c = '0;
    k_c         = '0;
    nxt_col_c   = '0;
    case (state_q)
      IDLE: begin
        col_d = '1;
        if (tick_c) begin
          state_d   = WAIT;
          cur_col_d = '0;
          col_d     = ~COLS'(1);
        end
      end
      WAIT: begin
        if (tick_c) begin
          row_lat_d = ~row_sync;
          r_d       = '0;
          state_d   = EVAL;
        end
      end
      EVAL: begin
        k_c = CODE_W'(32'(r_q) * COLS + 32'(cur_col_q));
        if (row_lat_q[r_q] == key_state[k_c]) begin
          cnt_d[k_c] = '0;
        end else if (32'(cnt_q[k_c]) + 32'd1 == DEBOUNCE) begin
          key_state_d[k_c] = ~key_state[k_c];
          cnt_d[k_c]       = '0;
          push_c           = 1'b1;
          push_data_c      = {key_state[k_c], k_c};
        end else begin
          cnt_d[k_c] = cnt_q[k_c] + DW'(1);
        end
        if (32'(r_q) == ROWS - 1) begin
          nxt_col_c = (32'(cur_col_q) == COLS - 1) ? '0 : cur_col_q + CW'(1);
          cur_col_d = nxt_col_c;
          col_d     = ~(COLS'(1) << nxt_col_c);
          state_d   = WAIT;
        end else begin
          r_d = r_q + RW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scanner state, column drive, debounce counters and key bitmap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cur_col_q <= '0;
      r_q       <= '0;
      row_lat_q <= '0;
      col       <= '1;
      key_state <= '0;
      for (int i = 0; i < int'(N); i++) cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cur_col_q <= cur_col_d;
      r_q       <= r_d;
      row_lat_q <= row_lat_d;
      col       <= col_d;
      key_state <= key_state_d;
      for (int i = 0; i < int'(N); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // FIFO control: a push into a full FIFO only succeeds alongside a pop.
  assign pop_c   = valid_q & evt.evt_ready;
  assign full_c  = (fill_q == FW'(FIFO_DEPTH));
  assign wr_en_c = push_c & (~full_c | pop_c);
  assign drop_c  = push_c & full_c & ~pop_c;
  assign fill_d  = fill_q + FW'(wr_en_c) - FW'(pop_c);

  assign evt.evt_valid = valid_q;
  assign evt.evt_data  = valid_q ? mem[rd_q] : '0;

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      fill_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (wr_en_c) wr_q <= wr_q + AW'(1);
      if (pop_c)   rd_q <= rd_q + AW'(1);
      fill_q  <= fill_d;
      valid_q <= (fill_d != '0);
    end
  end

  // FIFO storage; unread entries are masked at the output.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_q] <= push_data_c;
  end

  // Sticky drop flag; a drop outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop_c)  overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Bench for keypad_scan_fifo: scan-schedule/debounce/queue model plus directed scenarios.
module tb_keypad_scan_fifo;
  localparam int ROWS = 4, COLS = 4, SCAN_DIV = 16, DEBOUNCE = 2, FIFO_DEPTH = 4;
  localparam int N = ROWS * COLS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] key_state;
  logic        overflow;
  logic        ovf_clr = 1'b0;
  logic [15:0] pressed = '0;

  keypad_scan_fifo_if #(.DATA_W(5)) evt_if ();

  keypad_scan_fifo #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col), .evt(evt_if),
    .key_state(key_state), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Switch matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!col[c] && pressed[r*COLS+c]) row[r] = 1'b0;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Posedges seen since reset release.
  int pos_e = 0;
  always @(posedge clk) begin
    if (!rst_n) pos_e <= 0;
    else        pos_e <= pos_e + 1;
  end

  // Model state.
  int          model_e;
  logic [15:0] m_ks;
  int          m_cnt [N];
  logic [3:0]  m_lat;
  logic [4:0]  m_q [$];
  logic        m_ovf;
  logic [15:0] hist [3];
  logic        rdy_prev, clr_prev;
  logic [4:0]  pop_log [$];

  function automatic logic [3:0] exp_col(input int e);
    logic [3:0] one;
    int slot;
    one = 4'b0001;
    if (e < SCAN_DIV) return 4'hF;
    if (e < 2*SCAN_DIV + ROWS) return ~one;
    slot = (e - 2*SCAN_DIV - ROWS) / SCAN_DIV + 1;
    return ~(one << (slot % COLS));
  endfunction

  // Advance the model across posedge number e.
  task automatic step(input int e);
    int r, c, k;
    logic drop;
    drop = 1'b0;
    if (m_q.size() > 0 && rdy_prev) void'(m_q.pop_front());
    if (e >= 2*SCAN_DIV && (e % SCAN_DIV) == 0) begin
      c = (e / SCAN_DIV - 2) % COLS;
      for (int i = 0; i < ROWS; i++) m_lat[i] = hist[2][i*COLS+c];
    end else if (e > 2*SCAN_DIV && ((e - 1) % SCAN_DIV) < ROWS) begin
      r = (e - 1) % SCAN_DIV;
      c = ((e - 1) / SCAN_DIV - 2) % COLS;
      k = r*COLS + c;
      if (m_lat[r] == m_ks[k]) begin
        m_cnt[k] = 0;
      end else begin
        m_cnt[k]++;
        if (m_cnt[k] == DEBOUNCE) begin
          if (m_q.size() < FIFO_DEPTH) m_q.push_back({m_ks[k], 4'(k)});
          else drop = 1'b1;
          m_ks[k]  = ~m_ks[k];
          m_cnt[k] = 0;
        end
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (clr_prev) m_ovf = 1'b0;
  endtask

  // Model update and per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_e = 0;
      m_ks    = '0;
      m_lat   = '0;
      m_ovf   = 1'b0;
      m_q.delete();
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      for (int i = 0; i < 3; i++) hist[i] = '0;
    end else if (pos_e > model_e) begin
      model_e = pos_e;
      step(model_e);
    end
    check("col", 32'(col), 32'(exp_col(model_e)));
    check("key_state", 32'(key_state), 32'(m_ks));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("evt_valid", 32'(evt_if.evt_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) check("evt_data", 32'(evt_if.evt_data), 32'(m_q[0]));
    if (evt_if.evt_valid && evt_if.evt_ready) pop_log.push_back(evt_if.evt_data);
    hist[2]  = hist[1];
    hist[1]  = hist[0];
    hist[0]  = pressed;
    rdy_prev = evt_if.evt_ready;
    clr_prev = ovf_clr;
  end

  task automatic goto(input int tgt);
    int guard;
    guard = 0;
    while (pos_e < tgt && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (pos_e != tgt) begin
      n_tests++;
      n_fail++;
      $display("FAIL goto: reached edge %0d, wanted %0d", pos_e, tgt);
    end
  endtask

  initial begin
    evt_if.evt_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_col", 32'(col), 32'(4'hF));
    check("rst_valid", 32'(evt_if.evt_valid), 32'(1'b0));
    check("rst_data", 32'(evt_if.evt_data), 32'(5'h00));
    check("rst_keys", 32'(key_state), 32'(16'h0000));
    check("rst_ovf", 32'(overflow), 32'(1'b0));
    rst_n = 1'b1;

    // Column stepping; key 6 held for the press scenario.
    pressed[6] = 1'b1;
    goto(15);  check("col_idle", 32'(col), 32'(4'hF));
    goto(16);  check("col_c0", 32'(col), 32'(4'hE));
    goto(35);  check("col_c0_end", 32'(col), 32'(4'hE));
    goto(36);  check("col_c1", 32'(col), 32'(4'hD));
    goto(52);  check("col_c2", 32'(col), 32'(4'hB));
    goto(68);  check("col_c3", 32'(col), 32'(4'h7));
    goto(84);  check("col_wrap", 32'(col), 32'(4'hE));

    // Press of key 6 recognised on the second col-2 sample.
    goto(129); check("press_before", 32'(key_state), 32'(16'h0000));
    goto(130); check("press_keys", 32'(key_state), 32'(16'h0040));
    check("press_valid", 32'(evt_if.evt_valid), 32'(1'b1));
    check("press_data", 32'(evt_if.evt_data), 32'(5'b0_0110));
    goto(131); check("press_one_beat", 32'(evt_if.evt_valid), 32'(1'b0));

    // Release of key 6.
    goto(200);
    check("press_log_n", 32'(pop_log.size()), 32'd1);
    check("press_log0", 32'(pop_log[0]), 32'(5'b0_0110));
    pressed[6] = 1'b0;
    goto(321); check("rel_before", 32'(key_state), 32'(16'h0040));
    goto(322); check("rel_keys", 32'(key_state), 32'(16'h0000));
    check("rel_data", 32'(evt_if.evt_data), 32'(5'b1_0110));

    // Bounce: two isolated single-sample presses never reach DEBOUNCE.
    goto(340); pressed[6] = 1'b1;
    goto(390); pressed[6] = 1'b0;
    goto(460); pressed[6] = 1'b1;
    goto(520); pressed[6] = 1'b0;
    goto(530);
    check("bounce_keys", 32'(key_state), 32'(16'h0000));
    check("bounce_log_n", 32'(pop_log.size()), 32'd2);

    // Overflow: five presses with the consumer stalled.
    evt_if.evt_ready = 1'b0;
    goto(540); pressed = 16'h1113;
    goto(630);
    check("ovf_set", 32'(overflow), 32'(1'b1));
    check("ovf_keys", 32'(key_state), 32'(16'h1113));
    check("ovf_head", 32'(evt_if.evt_data), 32'(5'd0));
    evt_if.evt_ready = 1'b1;
    goto(640);
    check("ovf_log_n", 32'(pop_log.size()), 32'd6);
    check("ovf_pop0", 32'(pop_log[2]), 32'(5'd0));
    check("ovf_pop1", 32'(pop_log[3]), 32'(5'd4));
    check("ovf_pop2", 32'(pop_log[4]), 32'(5'd8));
    check("ovf_pop3", 32'(pop_log[5]), 32'(5'd12));
    check("ovf_hold", 32'(overflow), 32'(1'b1));
    ovf_clr = 1'b1;
    goto(641); ovf_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'(1'b0));

    // Fresh start, then reset during EVAL with key 9 still pending.
    goto(650); rst_n = 1'b0; pressed = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pressed = 16'h0202;
    goto(113);
    check("pre_abort_keys", 32'(key_state), 32'(16'h0002));
    check("pre_abort_valid", 32'(evt_if.evt_valid), 32'(1'b1));
    rst_n = 1'b0;
    #1;
    check("abort_col", 32'(col), 32'(4'hF));
    check("abort_valid", 32'(evt_if.evt_valid), 32'(1'b0));
    check("abort_keys", 32'(key_state), 32'(16'h0000));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    goto(15);  check("restart_idle", 32'(col), 32'(4'hF));
    goto(16);  check("restart_c0", 32'(col), 32'(4'hE));
    goto(100); check("restart_keys0", 32'(key_state), 32'(16'h0000));
    goto(116); check("restart_keys", 32'(key_state), 32'(16'h0202));
    goto(130);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
